vga_pixel_fifo: RTL and testbench

//   Elastic pixel buffer directly upstream of VGA_Top. It decouples a bursty pixel renderer

---
 rtl/vga_pixel_fifo.sv | 120 ++++++++++++
 tb/tb_vga_pixel_fifo.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fifo.sv
// Elastic pixel buffer between a bursty renderer and the fixed-rate VGA raster.
// One pixel popped per active-video cycle; underflow flagged and counted per frame.
module vga_pixel_fifo #(
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 16,
    parameter int                ADDR_W   = 4,
    parameter logic [DATA_W-1:0] BG_COLOR = '0
) (
    input  logic              pixel_clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              pix_req,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [DATA_W-1:0] color_data,
    output logic [ADDR_W:0]   level,
    output logic              underflow,
    output logic [7:0]        uf_count
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic              uf_q, uf_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic active;
    logic push;
    logic pop;
    logic starve;

    // A frame_start cycle discards any transfer, so it gates both sides.
    assign active   = (state_q == RUN) && !frame_start;
    assign wr_ready = active && (level_q != FULL_LVL);
    assign push     = wr_valid && wr_ready;
    assign pop      = active && pix_req && (level_q != '0);
    assign starve   = active && pix_req && (level_q == '0);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        color_d  = BG_COLOR;
        uf_d     = uf_q;
        cnt_d    = cnt_q;

        if (frame_start) begin
            state_d  = RUN;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            uf_d     = 1'b0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                color_d  = mem[rd_ptr_q];
            end
            if (push && !pop) begin
                level_d = level_q + 1'b1;
            end else if (pop && !push) begin
                level_d = level_q - 1'b1;
            end
            if (starve) begin
                uf_d = 1'b1;
                if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            color_q  <= BG_COLOR;
            uf_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            color_q  <= color_d;
            uf_q     <= uf_d;
            cnt_q    <= cnt_d;
        end
    end

    // Pixel storage carries no reset; only pointer-qualified entries are read.
    always_ff @(posedge pixel_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign color_data = color_q;
    assign level      = level_q;
    assign underflow  = uf_q;
    assign uf_count   = cnt_q;

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Directed + randomized bench for vga_pixel_fifo against a queue-based model.
module tb_vga_pixel_fifo;

    logic        pixel_clk;
    logic        reset;
    logic        frame_start;
    logic        pix_req;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic [15:0] color_data;
    logic [4:0]  level;
    logic        underflow;
    logic [7:0]  uf_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model
    logic [15:0] q[$];
    bit          m_run   = 0;
    logic [15:0] m_color = '0;
    bit          m_uf    = 0;
    int          m_cnt   = 0;

    vga_pixel_fifo dut (
        .pixel_clk  (pixel_clk),
        .reset      (reset),
        .frame_start(frame_start),
        .pix_req    (pix_req),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .color_data (color_data),
        .level      (level),
        .underflow  (underflow),
        .uf_count   (uf_count)
    );

    initial begin
        pixel_clk = 0;
        forever #5 pixel_clk = ~pixel_clk;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(string tag);
        chk({tag, ".color"}, 32'(color_data), 32'(m_color));
        chk({tag, ".level"}, 32'(level), 32'(q.size()));
        chk({tag, ".uf"}, 32'(underflow), 32'(m_uf));
        chk({tag, ".ufcnt"}, 32'(uf_count), 32'(m_cnt));
    endtask

    // Called at posedge+1; drives one cycle and checks the result.
    task automatic cycle(string tag, bit fs, bit pr, bit wv, logic [15:0] wd);
        bit exp_rdy;
        bit was_empty;
        frame_start = fs;
        pix_req     = pr;
        wr_valid    = wv;
        wr_data     = wd;
        #1;
        exp_rdy = m_run && !fs && (q.size() != 16);
        chk({tag, ".rdy"}, 32'(wr_ready), 32'(exp_rdy));
        m_color = 16'h0;
        if (fs) begin
            m_run = 1;
            q.delete();
            m_uf  = 0;
            m_cnt = 0;
        end else if (m_run) begin
            was_empty = (q.size() == 0);
            if (pr && !was_empty) m_color = q.pop_front();
            if (pr && was_empty) begin
                m_uf = 1;
                if (m_cnt < 255) m_cnt++;
            end
            if (wv && exp_rdy) q.push_back(wd);
        end
        @(posedge pixel_clk);
        #1;
        chk_outs(tag);
    endtask

    initial begin
        reset       = 0;
        frame_start = 0;
        pix_req     = 0;
        wr_valid    = 0;
        wr_data     = '0;
        #1;
        chk_outs("rst");
        chk("rst.rdy", 32'(wr_ready), 32'd0);
        repeat (2) @(posedge pixel_clk);
        #1;
        reset = 1;

        // IDLE ignores writes
        repeat (4) cycle("idle", 0, 0, 1, 16'(4 + $urandom_range(0, 255)));

        // Basic ordered pass-through
        cycle("t2fs", 1, 0, 0, 16'h0);
        cycle("t2w", 0, 0, 1, 16'h00FF);
        cycle("t2w", 0, 0, 1, 16'h00E0);
        cycle("t2w", 0, 0, 1, 16'h001C);
        repeat (3) cycle("t2r", 0, 1, 0, 16'h0);
        cycle("t2z", 0, 0, 0, 16'h0);

        // Fill to full, 17th word dropped, one pop frees a slot
        repeat (17) cycle("t3w", 0, 0, 1, 16'($urandom));
        cycle("t3r", 0, 1, 0, 16'h0);
        cycle("t3w", 0, 0, 1, 16'hBEEF);
        repeat (16) cycle("t3d", 0, 1, 0, 16'h0);

        // Underflow counting and frame flush
        repeat (3) cycle("t4u", 0, 1, 0, 16'h0);
        chk("t4.cnt3", 32'(uf_count), 32'd3);
        cycle("t4fs", 1, 0, 0, 16'h0);

        // Steady push+pop across pointer wrap
        repeat (8) cycle("t5w", 0, 0, 1, 16'($urandom));
        repeat (20) cycle("t5pp", 0, 1, 1, 16'($urandom));
        chk("t5.lvl8", 32'(level), 32'd8);

        // Asynchronous reset mid-stream
        cycle("t6fs", 1, 0, 0, 16'h0);
        repeat (5) cycle("t6w", 0, 0, 1, 16'($urandom));
        #2;
        reset = 0;
        #1;
        q.delete();
        m_run   = 0;
        m_color = '0;
        m_uf    = 0;
        m_cnt   = 0;
        chk_outs("t6rst");
        chk("t6rst.rdy", 32'(wr_ready), 32'd0);
        #2;
        reset = 1;
        @(posedge pixel_clk);
        #1;
        repeat (3) cycle("t6idle", 0, 1, 1, 16'($urandom));

        // Randomized traffic with occasional frame starts
        cycle("rfs", 1, 0, 0, 16'h0);
        for (int i = 0; i < 400; i++) begin
            cycle("rnd", ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 3) != 0),
                  16'($urandom));
        end

        // Underflow counter saturation
        cycle("satfs", 1, 0, 0, 16'h0);
        repeat (260) cycle("sat", 0, 1, 0, 16'h0);
        chk("sat.cnt", 32'(uf_count), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
